mmio_output_bank: RTL and testbench

Multi-channel memory-mapped output device on the processor's shared `abus`/`dbus` data bus. It holds `NCH` independent output registers, each `DEV_LEN` bits wide, at consecutive word addresses. A per-channel blink engine, driven by a shared prescaled counter, can periodically blank selected channels. It drives board outputs (LEDs, HEX digits) and supersedes single-register output devices in the system address map.

---
 rtl/mmio_output_bank.sv | 98 +++++++++
 tb/tb_mmio_output_bank.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/mmio_output_bank.sv
// mmio_output_bank: NCH memory-mapped output registers on abus/dbus with per-channel blinking.
// Blink engine, CTRL register and phase exist only when OUTDEV_BLINK_EN is defined.
module mmio_output_bank #(
    parameter int               DBITS       = 32,
    parameter int               DEV_LEN     = 10,
    parameter int               NCH         = 4,
    parameter logic [DBITS-1:0] BASE_ADDR   = 32'hF0000000,
    parameter logic [DBITS-1:0] CTRL_OFFSET = 32'h40,
    parameter int               BLINK_DIV   = 25000000
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [DBITS-1:0]       abus,
    inout  wire  [DBITS-1:0]       dbus,
    input  logic                   we,
    output logic [NCH*DEV_LEN-1:0] dev
);
    logic [DEV_LEN-1:0] data_q [NCH];
    logic [DEV_LEN-1:0] data_d [NCH];
    logic [NCH-1:0]     sel;
    logic [NCH-1:0]     blank;
    logic               ctrl_sel;
    logic               rd_en;
    logic [DBITS-1:0]   ctrl_rd;
    logic [DBITS-1:0]   rd_data;

    always_comb begin
        for (int i = 0; i < NCH; i++)
            sel[i] = abus == BASE_ADDR + DBITS'(4 * i);
    end

    always_comb begin
        data_d = data_q;
        for (int i = 0; i < NCH; i++)
            if (we && sel[i]) data_d[i] = dbus[DEV_LEN-1:0];
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) data_q <= '{default: '0};
        else          data_q <= data_d;

`ifdef OUTDEV_BLINK_EN
    localparam int CW = $clog2(BLINK_DIV);
    typedef enum logic {SHOW, BLANK} phase_t;
    phase_t         phase_q, phase_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [NCH-1:0] blink_en_q, blink_en_d;

    assign ctrl_sel = abus == BASE_ADDR + CTRL_OFFSET;

    // A CTRL write overrides the wrap so blinking restarts in SHOW with a fresh period.
    always_comb begin
        cnt_d      = cnt_q + CW'(1);
        phase_d    = phase_q;
        blink_en_d = blink_en_q;
        if (cnt_q == CW'(BLINK_DIV - 1)) begin
            cnt_d   = '0;
            phase_d = phase_q == SHOW ? BLANK : SHOW;
        end
        if (we && ctrl_sel) begin
            blink_en_d = dbus[NCH-1:0];
            cnt_d      = '0;
            phase_d    = SHOW;
        end
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            cnt_q      <= '0;
            phase_q    <= SHOW;
            blink_en_q <= '0;
        end else begin
            cnt_q      <= cnt_d;
            phase_q    <= phase_d;
            blink_en_q <= blink_en_d;
        end

    assign blank   = phase_q == BLANK ? blink_en_q : '0;
    assign ctrl_rd = {phase_q == BLANK, (DBITS-1-NCH)'(0), blink_en_q};
`else
    assign ctrl_sel = 1'b0;
    assign blank    = '0;
    assign ctrl_rd  = '0;
`endif

    always_comb begin
        rd_data = ctrl_sel ? ctrl_rd : '0;
        for (int i = 0; i < NCH; i++)
            if (sel[i]) rd_data = DBITS'(data_q[i]);
    end

    assign rd_en = !we && (|sel || ctrl_sel);
    assign dbus  = rd_en ? rd_data : 'z;

    for (genvar i = 0; i < NCH; i++) begin : g_dev
        assign dev[i*DEV_LEN +: DEV_LEN] = blank[i] ? '0 : data_q[i];
    end
endmodule

// File: tb/tb_mmio_output_bank.sv
// tb_mmio_output_bank: directed table plus blink/wrap/async-reset sequences for mmio_output_bank.
module tb_mmio_output_bank;
    localparam logic [31:0] BASE = 32'hF0000000;
    localparam logic [31:0] CTRL = 32'hF0000040;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic [39:0] exp_dev;
    } vec_t;

    logic        clk = 0;
    logic        reset_n = 0;
    logic [31:0] abus = 0;
    logic        we = 0;
    logic [31:0] drv = 0;
    logic        drv_en = 0;
    wire  [31:0] dbus;
    logic [39:0] dev;
    int          n_cmp = 0;
    int          n_bad = 0;

    assign dbus = drv_en ? drv : 'z;

    mmio_output_bank #(
        .DBITS(32), .DEV_LEN(10), .NCH(4), .BASE_ADDR(BASE),
        .CTRL_OFFSET(32'h40), .BLINK_DIV(4)
    ) dut (
        .clk(clk), .reset_n(reset_n), .abus(abus), .dbus(dbus), .we(we), .dev(dev)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        abus   = a;
        we     = 1;
        drv    = d;
        drv_en = 1;
        @(posedge clk);
        #1;
        we     = 0;
        drv_en = 0;
    endtask

    task automatic rd(input string name, input logic [31:0] a, input logic [31:0] exp);
        abus = a;
        we   = 0;
        #1;
        chk(name, {32'h0, dbus}, {32'h0, exp});
    endtask

    initial begin
        vec_t        vt[16];
        logic [31:0] zz;
        logic [31:0] ctrl_rst;
        logic [39:0] ed;
        logic        ph;
        zz = 32'hzzzzzzzz;
`ifdef OUTDEV_BLINK_EN
        ctrl_rst = 32'h0;
`else
        ctrl_rst = zz;
`endif
        vt[0]  = '{0, BASE + 32'h0,  32'h0,        32'h0,   40'h0};
        vt[1]  = '{0, BASE + 32'h4,  32'h0,        32'h0,   40'h0};
        vt[2]  = '{0, BASE + 32'h8,  32'h0,        32'h0,   40'h0};
        vt[3]  = '{0, BASE + 32'hC,  32'h0,        32'h0,   40'h0};
        vt[4]  = '{0, CTRL,          32'h0,        ctrl_rst, 40'h0};
        vt[5]  = '{1, BASE + 32'h8,  32'hFFFFF3A5, 32'h0,   {10'h0, 10'h3A5, 10'h0, 10'h0}};
        vt[6]  = '{0, BASE + 32'h8,  32'h0,        32'h3A5, {10'h0, 10'h3A5, 10'h0, 10'h0}};
        vt[7]  = '{1, BASE + 32'h6,  32'h155,      32'h0,   {10'h0, 10'h3A5, 10'h0, 10'h0}};
        vt[8]  = '{1, BASE + 32'h20, 32'h155,      32'h0,   {10'h0, 10'h3A5, 10'h0, 10'h0}};
        vt[9]  = '{0, BASE + 32'h6,  32'h0,        zz,      {10'h0, 10'h3A5, 10'h0, 10'h0}};
        vt[10] = '{0, BASE + 32'h20, 32'h0,        zz,      {10'h0, 10'h3A5, 10'h0, 10'h0}};
        vt[11] = '{0, BASE + 32'h0,  32'h0,        32'h0,   {10'h0, 10'h3A5, 10'h0, 10'h0}};
        vt[12] = '{0, BASE + 32'h4,  32'h0,        32'h0,   {10'h0, 10'h3A5, 10'h0, 10'h0}};
        vt[13] = '{0, BASE + 32'hC,  32'h0,        32'h0,   {10'h0, 10'h3A5, 10'h0, 10'h0}};
        vt[14] = '{1, BASE + 32'h4,  32'h1AB,      32'h0,   {10'h0, 10'h3A5, 10'h1AB, 10'h0}};
        vt[15] = '{0, BASE + 32'h4,  32'h0,        32'h1AB, {10'h0, 10'h3A5, 10'h1AB, 10'h0}};

        repeat (2) @(posedge clk);
        #1;
        chk("dev_in_reset", {24'h0, dev}, 64'h0);
        @(negedge clk);
        reset_n = 1;

        for (int k = 0; k < 16; k++) begin
            if (vt[k].we) wr(vt[k].addr, vt[k].wdata);
            else rd($sformatf("vec%0d_rd", k), vt[k].addr, vt[k].exp_rd);
            chk($sformatf("vec%0d_dev", k), {24'h0, dev}, {24'h0, vt[k].exp_dev});
        end

`ifdef OUTDEV_BLINK_EN
        wr(CTRL, 32'h2);
        for (int k = 0; k < 16; k++) begin
            ph = ((k / 4) % 2) == 1;
            ed = {10'h0, 10'h3A5, ph ? 10'h0 : 10'h1AB, 10'h0};
            chk($sformatf("blink%0d_dev", k), {24'h0, dev}, {24'h0, ed});
            rd($sformatf("blink%0d_ctrl", k), CTRL, {ph, 27'h0, 4'h2});
            rd($sformatf("blink%0d_ch1", k), BASE + 32'h4, 32'h1AB);
            @(posedge clk);
            #1;
        end
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rd("pre_wrap_ctrl", CTRL, 32'h2);
        wr(CTRL, 32'h2);
        for (int k = 0; k < 8; k++) begin
            ph = k >= 4;
            rd($sformatf("wrap%0d_ctrl", k), CTRL, {ph, 27'h0, 4'h2});
            chk($sformatf("wrap%0d_dev1", k), {54'h0, dev[19:10]}, {54'h0, ph ? 10'h0 : 10'h1AB});
            @(posedge clk);
            #1;
        end
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        rd("preblank_ctrl", CTRL, 32'h80000002);
        chk("preblank_dev", {24'h0, dev}, {24'h0, 10'h0, 10'h3A5, 10'h0, 10'h0});
        #2;
        reset_n = 0;
        #1;
        chk("areset_dev", {24'h0, dev}, 64'h0);
        rd("areset_ctrl", CTRL, 32'h0);
        rd("areset_ch2", BASE + 32'h8, 32'h0);
        @(negedge clk);
        reset_n = 1;
        wr(BASE + 32'h4, 32'h1AB);
`else
        wr(CTRL, 32'hF);
        rd("noblink_ctrl", CTRL, zz);
        for (int k = 0; k < 20; k++) begin
            chk($sformatf("steady%0d_dev1", k), {54'h0, dev[19:10]}, {54'h0, 10'h1AB});
            @(posedge clk);
            #1;
        end
`endif
        rd("final_ch1", BASE + 32'h4, 32'h1AB);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
